// File: rtl/alu_mult_seq32_if.sv
// alu_mult_seq32_if
// Bundles the three handshake groups of the sequential multiplier:
//   operand side : in_valid, in_ready, in_a (multiplier), in_b (multiplicand)
//   product side : out_valid, out_ready, out_prod {hi,lo}
//   ALU side     : alu_a, alu_b, alu_cmd (issued), alu_result, alu_carryout (returned)
// The multiplier is the initiator of the ALU command/result exchange, so it
// connects through the master modport. The slave modport is the view of
// everything around it: the operand source, the product sink and the shared ALU.
interface alu_mult_seq32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_cmd;
    logic [31:0] alu_result;
    logic        alu_carryout;

    modport master (
        input  in_valid, in_a, in_b, out_ready, alu_result, alu_carryout,
        output in_ready, out_valid, out_prod, alu_a, alu_b, alu_cmd
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, alu_result, alu_carryout,
        input  in_ready, out_valid, out_prod, alu_a, alu_b, alu_cmd
    );
endinterface

// File: rtl/alu_mult_seq32.sv
// alu_mult_seq32
// 32x32->64 shift-add multiplier that borrows the shared 32-bit ALU for every
// addition instead of owning an adder. Each ALU operation is held constant
// for SETTLE_CYCLES cycles and its result/carryout is captured on the edge
// that ends the last settle cycle.
//
// Parameter : SETTLE_CYCLES (1..15) cycles each ALU operation is held.
// Ports     : clk      rising-edge clock
//             reset_n  synchronous, active-low reset
//             bus      alu_mult_seq32_if.master (operand, product and ALU groups)
//
// Build option: define MULT_SIGNED_EN to treat operands as two's complement.
// The operands are then negated to magnitudes through the ALU, multiplied
// unsigned, and the 64-bit product is negated back when the signs differ.
// Without the macro the block is unsigned only.
module alu_mult_seq32 #(
    parameter int SETTLE_CYCLES = 4
) (
    input logic              clk,
    input logic              reset_n,
    alu_mult_seq32_if.master bus
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOAD   = 4'd1;
    localparam logic [3:0] ST_ITER   = 4'd2;
    localparam logic [3:0] ST_DONE   = 4'd3;
`ifdef MULT_SIGNED_EN
    localparam logic [3:0] ST_NEG_A  = 4'd4;
    localparam logic [3:0] ST_NEG_B  = 4'd5;
    localparam logic [3:0] ST_NEG_LO = 4'd6;
    localparam logic [3:0] ST_NOT_HI = 4'd7;
    localparam logic [3:0] ST_INC_HI = 4'd8;
    localparam logic [2:0] CMD_SUB   = 3'd1;
    localparam logic [2:0] CMD_NOR   = 3'd6;
`endif
    localparam logic [2:0] CMD_ADD   = 3'd0;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [3:0]  state;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mcand;
    logic [4:0]  iter_cnt;
    logic [3:0]  settle_cnt;
    logic        alu_active;
    logic        settle_done;
`ifdef MULT_SIGNED_EN
    logic        sign;
    logic        neg_c;
`endif

    assign settle_done   = alu_active && (settle_cnt == SETTLE_LAST);
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_prod  = {hi, lo};

    // ALU command and operands are a pure function of the state and of
    // registers that only change on capture edges, so they stay constant
    // for the whole settle window. Outside ALU states everything is zero.
    always_comb begin
        alu_active  = 1'b0;
        bus.alu_cmd = CMD_ADD;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        case (state)
            ST_ITER: begin
                alu_active = 1'b1;
                bus.alu_a  = hi;
                bus.alu_b  = mcand;
            end
`ifdef MULT_SIGNED_EN
            ST_NEG_A: begin
                alu_active  = 1'b1;
                bus.alu_cmd = CMD_SUB;
                bus.alu_b   = lo;
            end
            ST_NEG_B: begin
                alu_active  = 1'b1;
                bus.alu_cmd = CMD_SUB;
                bus.alu_b   = mcand;
            end
            ST_NEG_LO: begin
                alu_active  = 1'b1;
                bus.alu_cmd = CMD_SUB;
                bus.alu_b   = lo;
            end
            ST_NOT_HI: begin
                alu_active  = 1'b1;
                bus.alu_cmd = CMD_NOR;
                bus.alu_a   = hi;
                bus.alu_b   = hi;
            end
            ST_INC_HI: begin
                alu_active = 1'b1;
                bus.alu_a  = hi;
                bus.alu_b  = {31'd0, neg_c};
            end
`endif
            default: ;
        endcase
    end

    // Sequencer and datapath registers. Every ALU pass runs the full settle
    // window, even when its result is going to be discarded, so latency does
    // not depend on operand values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hi         <= '0;
            lo         <= '0;
            mcand      <= '0;
            iter_cnt   <= '0;
            settle_cnt <= '0;
`ifdef MULT_SIGNED_EN
            sign       <= 1'b0;
            neg_c      <= 1'b0;
`endif
        end else begin
            if (alu_active) begin
                settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        hi       <= '0;
                        lo       <= bus.in_a;
                        mcand    <= bus.in_b;
                        iter_cnt <= '0;
`ifdef MULT_SIGNED_EN
                        sign     <= bus.in_a[31] ^ bus.in_b[31];
                        state    <= ST_NEG_A;
`else
                        state    <= ST_LOAD;
`endif
                    end
                end

                ST_LOAD: state <= ST_ITER;

                // One shift-add step per pass; the ADD is always issued and
                // only kept when the current multiplier bit is set. The ALU
                // carryout becomes the new top bit of hi.
                ST_ITER: begin
                    if (settle_done) begin
                        if (lo[0]) begin
                            {hi, lo} <= {bus.alu_carryout, bus.alu_result, lo[31:1]};
                        end else begin
                            {hi, lo} <= {1'b0, hi, lo[31:1]};
                        end
                        iter_cnt <= iter_cnt + 5'd1;
                        if (iter_cnt == 5'd31) begin
`ifdef MULT_SIGNED_EN
                            state <= ST_NEG_LO;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end

`ifdef MULT_SIGNED_EN
                // Operand magnitudes: 0 - x kept only for negative operands.
                ST_NEG_A: begin
                    if (settle_done) begin
                        if (lo[31]) lo <= bus.alu_result;
                        state <= ST_NEG_B;
                    end
                end

                ST_NEG_B: begin
                    if (settle_done) begin
                        if (mcand[31]) mcand <= bus.alu_result;
                        state <= ST_ITER;
                    end
                end

                // 64-bit negate as ~{hi,lo}+1: the low word is 0-lo, and its
                // no-borrow flag is exactly the +1 carry into the high word.
                ST_NEG_LO: begin
                    if (settle_done) begin
                        if (sign) lo <= bus.alu_result;
                        neg_c <= bus.alu_carryout;
                        state <= ST_NOT_HI;
                    end
                end

                ST_NOT_HI: begin
                    if (settle_done) begin
                        if (sign) hi <= bus.alu_result;
                        state <= ST_INC_HI;
                    end
                end

                ST_INC_HI: begin
                    if (settle_done) begin
                        if (sign) hi <= bus.alu_result;
                        state <= ST_DONE;
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq32.sv
// tb_alu_mult_seq32
// Drives alu_mult_seq32 through its operand/product handshakes and plays the
// shared ALU itself. The ALU model returns a corrupted result until its
// inputs have been stable long enough, so a capture taken before the end of
// the settle window produces a wrong product. Expected products come from
// plain 64-bit multiplication (signed when MULT_SIGNED_EN is defined).
module tb_alu_mult_seq32;

    localparam int SETTLE   = 4;
    localparam int MAX_WAIT = 2000;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    alu_mult_seq32_if bus();

    alu_mult_seq32 #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU model with settle behaviour: inputs must be unchanged for
    // the whole window before the true result appears.
    logic [66:0] aluIn;
    logic [66:0] aluPrev = '0;
    int          aluStable = 0;
    logic        aluSettled;
    logic [32:0] aluIdeal;

    assign aluIn = {bus.alu_cmd, bus.alu_a, bus.alu_b};

    always @(posedge clk) begin
        if (aluIn != aluPrev) aluStable <= 0;
        else if (aluStable < 1000) aluStable <= aluStable + 1;
        aluPrev <= aluIn;
    end

    always_comb begin
        case (bus.alu_cmd)
            3'd0:    aluIdeal = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1:    aluIdeal = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
            3'd6:    aluIdeal = {1'b0, ~(bus.alu_a | bus.alu_b)};
            default: aluIdeal = '0;
        endcase
        aluSettled = (SETTLE < 2) || ((aluIn == aluPrev) && (aluStable >= SETTLE - 2));
        {bus.alu_carryout, bus.alu_result} = aluSettled ? aluIdeal : ~aluIdeal;
    end

    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    function automatic int refLatency();
`ifdef MULT_SIGNED_EN
        return 37 * SETTLE;
`else
        return 1 + 32 * SETTLE;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Full transaction: accept, wait for the product, optionally stall the
    // consumer for holdCycles while pulsing in_valid, then hand the product off.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int holdCycles);
        logic [63:0] expProd;
        int          lat;
        bit          cmdSeen;
        expProd = refProduct(a, b);
        checkOutput("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat     = 0;
        cmdSeen = 0;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            if (bus.alu_cmd != 3'd0) cmdSeen = 1;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(refLatency()));
        checkOutput("product", bus.out_prod, expProd);
`ifndef MULT_SIGNED_EN
        checkOutput("alu_cmd_add_only", 64'(cmdSeen), 64'd0);
`endif
        for (int h = 0; h < holdCycles; h++) begin
            bus.in_valid = h[0];
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            @(posedge clk); #1;
            checkOutput("hold_out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("hold_product", bus.out_prod, expProd);
            checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("hold_alu_idle", {29'd0, bus.alu_cmd, bus.alu_a | bus.alu_b}, 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("release_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("release_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_out_prod", bus.out_prod, 64'd0);
        checkOutput("reset_alu_cmd", 64'(bus.alu_cmd), 64'd0);
        checkOutput("reset_alu_ops", 64'(bus.alu_a | bus.alu_b), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed products");
        applyStimulus(32'd3, 32'd5, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(32'd0, 32'h1234_5678, 0);
        applyStimulus(32'h8000_0000, 32'd2, 20);

        $display("[TB] reset during iteration");
        bus.in_a     = 32'hDEAD_BEEF;
        bus.in_b     = 32'h0BAD_F00D;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10 * SETTLE) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("abort_out_prod", bus.out_prod, 64'd0);
        checkOutput("abort_alu_idle", {29'd0, bus.alu_cmd, bus.alu_a | bus.alu_b}, 64'd0);
        applyStimulus(32'd7, 32'd6, 0);

        $display("[TB] sign-sensitive operands");
        applyStimulus(32'hFFFF_FFFD, 32'd5, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(32'h8000_0000, 32'd1, 0);

        $display("[TB] random operands");
        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom, $urandom, (i % 2 == 1) ? 3 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
